// File: rtl/spi_wb_pkg.sv
// spi_wb_pkg -- shared definitions for the SPI-to-Wishbone bridge.
//   state_t      : bridge FSM states (also exported as a debug output)
//   MARKER_BYTE  : byte returned once a Wishbone cycle has completed
//   IDLE_BYTE    : byte returned whenever there is nothing to report
//   CMD_*        : bit positions inside the command byte
package spi_wb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_DATA = 3'd5
  } state_t;

  localparam logic [7:0] MARKER_BYTE = 8'h55;
  localparam logic [7:0] IDLE_BYTE   = 8'h00;

  localparam int CMD_W_BIT   = 7;
  localparam int CMD_CNT_MSB = 3;
  localparam int CMD_CNT_LSB = 0;

endpackage

// File: rtl/spi_wb_bridge_if.sv
// spi_wb_bridge_if -- Wishbone classic single-master bus bundle.
//   master modport : the bridge (drives cyc/stb/we/adr/dat_o, samples dat_i/ack)
//   slave modport  : the target (drives dat_i/ack)
// Handshake: a request is pending while wb_stb is high; the slave completes
// it by raising wb_ack for one cycle, in which wb_dat_i is valid for reads.
// An ack seen while wb_stb is low carries no meaning and is dropped.
interface spi_wb_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    input  wb_dat_i, wb_ack
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o,
    output wb_dat_i, wb_ack
  );
endinterface

// File: rtl/spi_wb_shreg.sv
// spi_wb_shreg -- MSB-first byte shift / parallel load register.
//   clk, rst_n : clock, asynchronous active-low reset (clears q)
//   load       : capture load_val (has priority over shift)
//   load_val   : parallel word
//   shift      : shift q left by one byte, shift_in enters at the bottom
//   shift_in   : incoming byte
//   q          : register contents; the top byte is the next byte out
module spi_wb_shreg #(
  parameter int BYTES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [8*BYTES-1:0] load_val,
  input  logic               shift,
  input  logic [7:0]         shift_in,
  output logic [8*BYTES-1:0] q
);
  localparam int W = 8 * BYTES;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      // Shift-and-or form keeps BYTES=1 legal (no zero-width slice).
      q <= (q << 8) | W'(shift_in);
    end
  end
endmodule

// File: rtl/spi_wb_bridge.sv
// spi_wb_bridge -- turns a byte stream from an SPI slave shifter into
// Wishbone single/burst reads and writes.
//   clk, rst_n       : clock, asynchronous active-low reset
//   rx_data, rx_stb  : received byte and its one-cycle strobe
//   tx_data, tx_stb  : reply byte, updated one cycle after each rx_stb
//   wb               : Wishbone master (spi_wb_bridge_if.master)
//   state            : current FSM state, for observation only
// Protocol: command byte (bit7 = write, bits3:0 = words-1), ADDR_BYTES
// address bytes MSB first, then per word either DATA_BYTES write bytes or
// polling bytes. Polls return 0x00 until the bus cycle is done, then 0x55,
// after which read data follows MSB first.
// Build option SPI_WB_BRIDGE_BURST_EN: when defined, the word count is
// honoured and the address auto-increments; otherwise every command moves
// exactly one word.
module spi_wb_bridge import spi_wb_pkg::*; #(
  parameter int ADDR_BYTES = 2,
  parameter int DATA_BYTES = 4,
  parameter int BURST_MAX  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          rx_data,
  input  logic                rx_stb,
  output logic [7:0]          tx_data,
  output logic                tx_stb,
  spi_wb_bridge_if.master     wb,
  output state_t              state
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  if (ADDR_BYTES < 1 || ADDR_BYTES > 4 || DATA_BYTES < 1 || DATA_BYTES > 4 ||
      BURST_MAX < 1 || BURST_MAX > 16) begin : g_param_check
    $error("spi_wb_bridge: parameter out of range");
  end

  state_t          state_q, state_n;
  logic [AW-1:0]   adr_q, adr_n;
  logic            stb_q, stb_n;
  logic            we_q, we_n;
  logic            is_wr_q, is_wr_n;
  logic [1:0]      bcnt_q, bcnt_n;
  logic [7:0]      tx_n;
  logic            wr_shift, rd_load, rd_shift, word_done;
  logic [DW-1:0]   wr_q, rd_q;
`ifdef SPI_WB_BRIDGE_BURST_EN
  localparam logic [3:0] CNT_MAX = 4'(BURST_MAX - 1);
  logic [3:0]      cnt_q, cnt_n;
`endif

  spi_wb_shreg #(.BYTES(DATA_BYTES)) u_wr_shreg (
    .clk(clk), .rst_n(rst_n), .load(1'b0), .load_val('0),
    .shift(wr_shift), .shift_in(rx_data), .q(wr_q)
  );

  spi_wb_shreg #(.BYTES(DATA_BYTES)) u_rd_shreg (
    .clk(clk), .rst_n(rst_n), .load(rd_load), .load_val(wb.wb_dat_i),
    .shift(rd_shift), .shift_in(IDLE_BYTE), .q(rd_q)
  );

  always_comb begin
    state_n   = state_q;
    adr_n     = adr_q;
    stb_n     = stb_q;
    we_n      = we_q;
    is_wr_n   = is_wr_q;
    bcnt_n    = bcnt_q;
    tx_n      = IDLE_BYTE;
    wr_shift  = 1'b0;
    rd_load   = 1'b0;
    rd_shift  = 1'b0;
    word_done = 1'b0;
`ifdef SPI_WB_BRIDGE_BURST_EN
    cnt_n     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_stb && rx_data != IDLE_BYTE) begin
          state_n = ST_ADDR;
          is_wr_n = rx_data[CMD_W_BIT];
          bcnt_n  = '0;
`ifdef SPI_WB_BRIDGE_BURST_EN
          cnt_n   = (rx_data[CMD_CNT_MSB:CMD_CNT_LSB] > CNT_MAX) ?
                    CNT_MAX : rx_data[CMD_CNT_MSB:CMD_CNT_LSB];
`endif
        end
      end
      ST_ADDR: begin
        if (rx_stb) begin
          adr_n = (adr_q << 8) | AW'(rx_data);
          if (bcnt_q == 2'(ADDR_BYTES - 1)) begin
            bcnt_n = '0;
            if (is_wr_q) begin
              state_n = ST_WR_DATA;
            end else begin
              stb_n   = 1'b1;
              state_n = ST_RD_WAIT;
            end
          end else begin
            bcnt_n = bcnt_q + 2'd1;
          end
        end
      end
      ST_WR_DATA: begin
        if (rx_stb) begin
          wr_shift = 1'b1;
          if (bcnt_q == 2'(DATA_BYTES - 1)) begin
            bcnt_n  = '0;
            stb_n   = 1'b1;
            we_n    = 1'b1;
            state_n = ST_WR_WAIT;
          end else begin
            bcnt_n = bcnt_q + 2'd1;
          end
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        // stb low inside a WAIT state means the ack has already been seen.
        // A byte arriving together with the ack still reports 0x00.
        if (stb_q) begin
          if (wb.wb_ack) begin
            stb_n   = 1'b0;
            we_n    = 1'b0;
            rd_load = (state_q == ST_RD_WAIT);
          end
        end else if (rx_stb) begin
          tx_n = MARKER_BYTE;
          if (state_q == ST_RD_WAIT) begin
            state_n = ST_RD_DATA;
            bcnt_n  = '0;
          end else begin
            word_done = 1'b1;
          end
        end
      end
      ST_RD_DATA: begin
        if (rx_stb) begin
          tx_n     = 8'(rd_q >> (DW - 8));
          rd_shift = 1'b1;
          if (bcnt_q == 2'(DATA_BYTES - 1)) begin
            bcnt_n    = '0;
            word_done = 1'b1;
          end else begin
            bcnt_n = bcnt_q + 2'd1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    if (word_done) begin
`ifdef SPI_WB_BRIDGE_BURST_EN
      if (cnt_q != 4'd0) begin
        cnt_n = cnt_q - 4'd1;
        adr_n = adr_q + AW'(1);
        if (is_wr_q) begin
          state_n = ST_WR_DATA;
        end else begin
          stb_n   = 1'b1;
          state_n = ST_RD_WAIT;
        end
      end else begin
        state_n = ST_IDLE;
      end
`else
      state_n = ST_IDLE;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      is_wr_q <= 1'b0;
      bcnt_q  <= '0;
      tx_data <= IDLE_BYTE;
      tx_stb  <= 1'b0;
`ifdef SPI_WB_BRIDGE_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_n;
      adr_q   <= adr_n;
      stb_q   <= stb_n;
      we_q    <= we_n;
      is_wr_q <= is_wr_n;
      bcnt_q  <= bcnt_n;
      tx_stb  <= rx_stb;
      if (rx_stb) begin
        tx_data <= tx_n;
      end
`ifdef SPI_WB_BRIDGE_BURST_EN
      cnt_q   <= cnt_n;
`endif
    end
  end

  assign wb.wb_cyc   = stb_q;
  assign wb.wb_stb   = stb_q;
  assign wb.wb_we    = we_q;
  assign wb.wb_adr   = adr_q;
  assign wb.wb_dat_o = wr_q;
  assign state       = state_q;

endmodule
